// File: rtl/ahb_ram_slv.sv
// AHB-Lite RAM responder: single-port word RAM behind an address/data-phase
// pipeline with optional wait states, byte-lane writes and two-cycle ERROR.
module ahb_ram_slv #(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel_i,
  input  logic [1:0]  htrans_i,
  input  logic [31:0] haddr_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  input  logic [2:0]  hburst_i,
  input  logic [3:0]  hprot_i,
  input  logic        hmastlock_i,
  input  logic [31:0] hwdata_i,
  input  logic        hready_i,
  output logic        hreadyout_o,
  output logic        hresp_o,
  output logic [31:0] hrdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  dph_q, dph_d;     // an OKAY data phase is outstanding
  logic                  dwr_q, dwr_d;
  logic [ADDR_WIDTH-1:0] didx_q, didx_d;
  logic [3:0]            dbe_q, dbe_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           mem_q [DEPTH];

  logic [31:0]           off;
  logic                  in_range;
  logic                  err_req;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] idx_req;
  logic [3:0]            be_req;
  logic [31:0]           wmask;
  logic [31:0]           wr_word;
  logic [31:0]           rd_word;
  logic                  wr_fire;

  logic unused_ok;
  assign unused_ok = ^{htrans_i[0], hburst_i, hprot_i, hmastlock_i, off[1:0]};

  assign off      = haddr_i - BASE_ADDR;
  assign in_range = (haddr_i >= BASE_ADDR) && (off[31:ADDR_WIDTH+2] == '0);
  assign err_req  = !in_range || (hsize_i > 3'd2) ||
                    ((hsize_i == 3'd1) && haddr_i[0]) ||
                    ((hsize_i == 3'd2) && (haddr_i[1:0] != 2'b00));
  assign accept   = hsel_i && hready_i && htrans_i[1] && hreadyout_o;
  assign idx_req  = off[ADDR_WIDTH+1:2];
  assign wr_fire  = dph_q && dwr_q && hreadyout_o;

  always_comb begin
    be_req = 4'b1111;
    case (hsize_i[1:0])
      2'd0:    be_req = 4'b0001 << haddr_i[1:0];
      2'd1:    be_req = haddr_i[1] ? 4'b1100 : 4'b0011;
      default: be_req = 4'b1111;
    endcase
  end

  always_comb begin
    wmask = '0;
    for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{dbe_q[b]}};
  end

  // A read hitting the word being written this edge sees the merged lanes.
  assign wr_word = (mem_q[didx_q] & ~wmask) | (hwdata_i & wmask);
  assign rd_word = (wr_fire && (didx_q == idx_req)) ? wr_word : mem_q[idx_req];

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[didx_q] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dph_q   <= 1'b0;
      dwr_q   <= 1'b0;
      didx_q  <= '0;
      dbe_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dph_q   <= dph_d;
      dwr_q   <= dwr_d;
      didx_q  <= didx_d;
      dbe_q   <= dbe_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dph_d   = dph_q;
    dwr_d   = dwr_q;
    didx_d  = didx_q;
    dbe_d   = dbe_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (hreadyout_o) dph_d = 1'b0;
    if (accept) begin
      if (err_req) begin
        state_d = ST_ERR1;
      end else begin
        dph_d  = 1'b1;
        dwr_d  = hwrite_i;
        didx_d = idx_req;
        dbe_d  = be_req;
        if (!hwrite_i) rdata_d = rd_word;
        if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_STATES - 1);
        end
      end
    end
  end

  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = 1'b0;
    case (state_q)
      ST_WAIT: hreadyout_o = 1'b0;
      ST_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = 1'b1;
      end
      ST_ERR2: hresp_o = 1'b1;
      default: ;
    endcase
  end

  assign hrdata_o = rdata_q;

endmodule

// File: tb/tb_ahb_ram_slv.sv
// Bench for ahb_ram_slv: a zero-wait and a three-wait instance driven by
// directed transfers, checked every cycle against a transfer-level model.
module tb_ahb_ram_slv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel0, hsel3;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        ro0, rs0, ro3, rs3;
  logic [31:0] rd0, rd3;

  int checks   = 0;
  int failures = 0;

  // Entry: {check_data, hreadyout, hresp, hrdata}
  logic [34:0] exp0_q[$];
  logic [34:0] exp3_q[$];
  logic [31:0] mem_m  [2][4096];
  logic [31:0] last_m [2];

  always #5 clk = ~clk;

  ahb_ram_slv #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .hsel_i(hsel0), .htrans_i(htrans),
    .haddr_i(haddr), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000),
    .hprot_i(4'b0011), .hmastlock_i(1'b0), .hwdata_i(hwdata), .hready_i(ro0),
    .hreadyout_o(ro0), .hresp_o(rs0), .hrdata_o(rd0)
  );

  ahb_ram_slv #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .hsel_i(hsel3), .htrans_i(htrans),
    .haddr_i(haddr), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b001),
    .hprot_i(4'b0011), .hmastlock_i(1'b0), .hwdata_i(hwdata), .hready_i(ro3),
    .hreadyout_o(ro3), .hresp_o(rs3), .hrdata_o(rd3)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, exp);
    end
  endtask

  function automatic logic [34:0] mk(input bit c, input bit r, input bit s, input logic [31:0] d);
    return {c, r, s, d};
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit model_err(input logic [31:0] addr, input logic [2:0] size);
    return (addr >= 32'h4000) || (size > 3'd2) ||
           ((size == 3'd1) && (addr[0] != 1'b0)) ||
           ((size == 3'd2) && (addr[1:0] != 2'b00));
  endfunction

  task automatic push(input int d, input logic [34:0] e);
    if (d == 0) exp0_q.push_back(e);
    else        exp3_q.push_back(e);
  endtask

  // Expected per-cycle data-phase response of one transfer; updates model RAM.
  task automatic model_resp(input int d, input bit wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wdata, output int n);
    int idx;
    int k;
    idx = int'(addr[13:2]);
    k   = int'(addr[1:0]);
    if (model_err(addr, size)) begin
      push(d, mk(1, 0, 1, last_m[d]));
      push(d, mk(1, 1, 1, last_m[d]));
      n = 2;
    end else begin
      for (int i = 0; i < ws_of(d); i++) push(d, mk(0, 0, 0, 32'h0));
      if (wr) begin
        case (size)
          3'd0:    mem_m[d][idx][8*k +: 8]   = wdata[8*k +: 8];
          3'd1:    mem_m[d][idx][8*k +: 16]  = wdata[8*k +: 16];
          default: mem_m[d][idx]             = wdata;
        endcase
      end else begin
        last_m[d] = mem_m[d][idx];
      end
      push(d, mk(1, 1, 0, last_m[d]));
      n = ws_of(d) + 1;
    end
  endtask

  task automatic cmp_one(input int d, input logic rdy, input logic rsp, input logic [31:0] dat);
    logic [34:0] e;
    if (d == 0) e = (exp0_q.size() > 0) ? exp0_q.pop_front() : mk(1, 1, 0, last_m[0]);
    else        e = (exp3_q.size() > 0) ? exp3_q.pop_front() : mk(1, 1, 0, last_m[1]);
    check($sformatf("dut%0d_hreadyout", d), {31'b0, rdy}, {31'b0, e[33]});
    check($sformatf("dut%0d_hresp", d),     {31'b0, rsp}, {31'b0, e[32]});
    if (e[34]) check($sformatf("dut%0d_hrdata", d), dat, e[31:0]);
  endtask

  always @(negedge clk) begin
    cmp_one(0, ro0, rs0, rd0);
    cmp_one(1, ro3, rs3, rd3);
  end

  // ---------------- driver tasks ----------------
  task automatic set_sel(input int d, input bit v);
    if (d == 0) hsel0 = v;
    else        hsel3 = v;
  endtask

  task automatic addr_phase(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] size);
    set_sel(d, 1'b1);
    htrans = 2'b10;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
  endtask

  task automatic go_idle(input int d);
    set_sel(d, 1'b0);
    htrans = 2'b00;
  endtask

  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata);
    int n;
    addr_phase(d, wr, addr, size);
    @(posedge clk); #1;
    go_idle(d);
    hwdata = wdata;
    model_resp(d, wr, addr, size, wdata, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Write whose data phase overlaps the next read's address phase.
  task automatic wr_then_rd(input logic [31:0] wa, input logic [2:0] ws, input logic [31:0] wdata,
                            input logic [31:0] ra);
    int n1, n2;
    addr_phase(0, 1'b1, wa, ws);
    @(posedge clk); #1;
    model_resp(0, 1'b1, wa, ws, wdata, n1);
    model_resp(0, 1'b0, ra, 3'd2, 32'h0, n2);
    addr_phase(0, 1'b0, ra, 3'd2);
    hwdata = wdata;
    @(posedge clk); #1;
    go_idle(0);
    repeat (n2) @(posedge clk);
    #1;
  endtask

  // Error transfer, then a read whose address phase lands in the second error cycle.
  task automatic err_then_rd(input int d, input logic [31:0] ea, input logic [31:0] ra);
    int n1, n2;
    addr_phase(d, 1'b0, ea, 3'd2);
    @(posedge clk); #1;
    go_idle(d);
    model_resp(d, 1'b0, ea, 3'd2, 32'h0, n1);
    model_resp(d, 1'b0, ra, 3'd2, 32'h0, n2);
    @(posedge clk); #1;
    addr_phase(d, 1'b0, ra, 3'd2);
    @(posedge clk); #1;
    go_idle(d);
    repeat (n2) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    exp0_q.delete();
    exp3_q.delete();
    last_m[0] = 32'h0;
    last_m[1] = 32'h0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4096; i++) mem_m[d][i] = 32'h0;
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    htrans = 2'b00;
    haddr  = 32'h0;
    hwrite = 1'b0;
    hsize  = 3'd2;
    hwdata = 32'h0;
    apply_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_hreadyout", {31'b0, ro0}, 32'd1);
    check("reset_hresp",     {31'b0, rs0}, 32'd0);
    check("reset_hrdata",    rd0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait word write and read
    xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);
    check("t1_read_lit", rd0, 32'hDEAD_BEEF);

    // byte write forwarded into the following read
    xfer(0, 1'b1, 32'h10, 3'd2, 32'h1122_3344);
    wr_then_rd(32'h13, 3'd0, 32'hAA55_6677, 32'h10);
    check("t2_forward_lit", rd0, 32'hAA22_3344);

    // out-of-range errors; aliased error write must not corrupt word 0x10
    xfer(0, 1'b1, 32'h20, 3'd2, 32'hCAFE_F00D);
    err_then_rd(0, 32'h4000, 32'h20);
    check("t3_err2_accept_lit", rd0, 32'hCAFE_F00D);
    xfer(0, 1'b1, 32'h4010, 3'd2, 32'hFFFF_FFFF);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);
    check("t3_ram_unchanged_lit", rd0, 32'hAA22_3344);

    // size/alignment errors, then legal half and byte lanes
    xfer(0, 1'b1, 32'h21, 3'd1, 32'h1111_1111);
    xfer(0, 1'b1, 32'h22, 3'd2, 32'h2222_2222);
    xfer(0, 1'b1, 32'h20, 3'd3, 32'h3333_3333);
    xfer(0, 1'b0, 32'h20, 3'd2, 32'h0);
    check("t4_err_no_write_lit", rd0, 32'hCAFE_F00D);
    xfer(0, 1'b1, 32'h22, 3'd1, 32'hBEEF_1234);
    xfer(0, 1'b1, 32'h21, 3'd0, 32'h0000_5500);
    xfer(0, 1'b0, 32'h20, 3'd2, 32'h0);
    check("t4_lanes_lit", rd0, 32'hBEEF_550D);

    // three wait states
    xfer(1, 1'b1, 32'h0, 3'd2, 32'h0102_0304);
    xfer(1, 1'b0, 32'h0, 3'd2, 32'h0);
    check("t5_wait_read_lit", rd3, 32'h0102_0304);
    err_then_rd(1, 32'h4000, 32'h0);

    // BUSY / IDLE / unselected NONSEQ: zero-wait OKAY, no state change
    hsel0 = 1'b1; hsel3 = 1'b1; htrans = 2'b01; haddr = 32'h4001; hsize = 3'd3;
    @(posedge clk); #1;
    htrans = 2'b00;
    @(posedge clk); #1;
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'b10;
    @(posedge clk); #1;
    htrans = 2'b00; hsize = 3'd2;
    @(posedge clk); #1;

    // reset during a write wait state
    addr_phase(1, 1'b1, 32'h0, 3'd2);
    @(posedge clk); #1;
    go_idle(1);
    hwdata = 32'hFFFF_FFFF;
    push(1, mk(0, 0, 0, 32'h0));
    @(posedge clk); #1;
    apply_reset();
    #1;
    check("t6_rst_hreadyout", {31'b0, ro3}, 32'd1);
    check("t6_rst_hresp",     {31'b0, rs3}, 32'd0);
    check("t6_rst_hrdata",    rd3, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h0, 3'd2, 32'h0);
    check("t6_word_unchanged_lit", rd3, 32'h0102_0304);
    xfer(0, 1'b0, 32'h20, 3'd2, 32'h0);
    check("t6_ram_survives_reset_lit", rd0, 32'hBEEF_550D);

    n = exp0_q.size() + exp3_q.size();
    check("queues_drained", n, 32'd0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
